// File: rtl/xpb_gen_pkg.sv
// Shared types and constants for the XPB lookup-table generator.
package xpb_gen_pkg;

    localparam int unsigned XPB_DATA_W  = 1024;
    localparam int unsigned XPB_DIGIT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ADD,
        ST_SUB,
        ST_DONE
    } xpb_state_e;

    function automatic int unsigned xpb_entries(input int unsigned digit_w);
        return 32'd1 << digit_w;
    endfunction

endpackage

// File: rtl/mod_add_sel.sv
// Accumulator for j*B mod M: registered acc+B, then conditional subtract of M.
module mod_add_sel
    import xpb_gen_pkg::*;
#(
    parameter int unsigned DATA_W = XPB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic              sub_i,
    input  logic [DATA_W-1:0] base_i,
    input  logic [DATA_W-1:0] modulus_i,
    output logic [DATA_W-1:0] acc_o
);

    logic [DATA_W:0]   sum_q, sum_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W+1:0] diff;

    always_comb begin
        // Extra top bit is the borrow: set means sum < M, keep sum unchanged.
        diff  = {1'b0, sum_q} - {2'b00, modulus_i};
        sum_d = sum_q;
        acc_d = acc_q;
        if (clr_i) begin
            sum_d = '0;
            acc_d = '0;
        end else begin
            if (add_i) sum_d = {1'b0, acc_q} + {1'b0, base_i};
            if (sub_i) acc_d = diff[DATA_W+1] ? sum_q[DATA_W-1:0] : diff[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            acc_q <= '0;
        end else begin
            sum_q <= sum_d;
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/xpb_table_gen.sv
// Fills the XPB table RAM with j*base mod modulus for every digit value j.
// Optional B >= M range check with sticky err port: define XPB_GEN_CHECK_EN.
module xpb_table_gen
    import xpb_gen_pkg::*;
#(
    parameter int unsigned DATA_W  = XPB_DATA_W,
    parameter int unsigned DIGIT_W = XPB_DIGIT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_W-1:0]  modulus,
    input  logic [DATA_W-1:0]  base,
    output logic               busy,
    output logic               done,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [DIGIT_W-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data
`ifdef XPB_GEN_CHECK_EN
    ,
    output logic               err
`endif
);

    localparam logic [DIGIT_W-1:0] LAST_IDX = DIGIT_W'(xpb_entries(DIGIT_W) - 1);

    xpb_state_e         state_q, state_d;
    logic [DIGIT_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]  m_q, m_d, b_q, b_d;
    logic               clr, add_en, sub_en;
    logic [DATA_W-1:0]  acc;
`ifdef XPB_GEN_CHECK_EN
    logic               err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        m_d     = m_q;
        b_d     = b_q;
        clr     = 1'b0;
        add_en  = 1'b0;
        sub_en  = 1'b0;
`ifdef XPB_GEN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = modulus;
                    b_d     = base;
                    idx_d   = '0;
                    clr     = 1'b1;
                    state_d = ST_WRITE;
`ifdef XPB_GEN_CHECK_EN
                    err_d = (base >= modulus);
                    if (base >= modulus) state_d = ST_DONE;
`endif
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_ADD;
                    end
                end
            end
            ST_ADD: begin
                add_en  = 1'b1;
                state_d = ST_SUB;
            end
            ST_SUB: begin
                sub_en  = 1'b1;
                state_d = ST_WRITE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            m_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            m_q     <= m_d;
            b_q     <= b_d;
        end
    end

`ifdef XPB_GEN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign err = err_q;
`endif

    mod_add_sel #(.DATA_W(DATA_W)) u_mod_add_sel (
        .clk       (clk),
        .rst       (reset),
        .clr_i     (clr),
        .add_i     (add_en),
        .sub_i     (sub_en),
        .base_i    (b_q),
        .modulus_i (m_q),
        .acc_o     (acc)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign wr_valid = (state_q == ST_WRITE);
    assign wr_addr  = idx_q;
    assign wr_data  = acc;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed/random bench for xpb_table_gen against an arithmetic j*B mod M model.
module tb_xpb_table_gen;

    localparam int W = 1024;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset, start, wr_ready;
    logic [W-1:0] modulus, base;
    logic         busy, done, wr_valid;
    logic [4:0]   wr_addr;
    logic [W-1:0] wr_data;
`ifdef XPB_GEN_CHECK_EN
    logic         err;
`endif

    xpb_table_gen #(.DATA_W(W), .DIGIT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .modulus  (modulus),
        .base     (base),
        .busy     (busy),
        .done     (done),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
`ifdef XPB_GEN_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Run bookkeeping: written by the stimulus only; the monitor restarts on a new run_id.
    int t0 = 0;
    int run_id = 0;

    // Monitor-owned state.
    int           seen_id = 0;
    logic [4:0]   log_addr[$];
    logic [W-1:0] log_data[$];
    int           log_cyc[$];
    int           done_cnt, done_at, stall_err;
    bit           stall_pend;
    logic [4:0]   st_addr;
    logic [W-1:0] st_data;
    logic         busy0, busy1, busy_done, busy_after;

    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id = run_id;
            log_addr.delete();
            log_data.delete();
            log_cyc.delete();
            done_cnt = 0; done_at = -1; stall_err = 0; stall_pend = 0;
            busy0 = 1'bx; busy1 = 1'bx; busy_done = 1'bx; busy_after = 1'bx;
        end
        if (run_id != 0 && !reset) begin
            if (wr_valid && wr_ready) begin
                log_addr.push_back(wr_addr);
                log_data.push_back(wr_data);
                log_cyc.push_back(cyc - t0);
            end
            if (stall_pend && !(wr_valid && wr_addr == st_addr && wr_data == st_data))
                stall_err++;
            stall_pend = wr_valid && !wr_ready;
            st_addr = wr_addr;
            st_data = wr_data;
            if (cyc - t0 == 0) busy0 = busy;
            if (cyc - t0 == 1) busy1 = busy;
            if (done_at >= 0 && cyc - t0 == done_at + 1) busy_after = busy;
            if (done) begin
                done_cnt++;
                done_at = cyc - t0;
                busy_done = busy;
            end
        end
    end

    function automatic logic [W-1:0] ref_entry(input logic [W-1:0] m, input logic [W-1:0] b, input int j);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, b} * (2*W)'(j);
        return W'(p % {{W{1'b0}}, m});
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed lo=%0h hi=%0h expected lo=%0h hi=%0h",
                   tag, obs[127:0], obs[W-1:W-64], exp[127:0], exp[W-1:W-64]);
        end
    endtask

    task automatic run_table(input logic [W-1:0] m, input logic [W-1:0] b, input bit rand_ready,
                             input int poke_at, input int rst_at, output bit finished);
        @(posedge clk); #1;
        modulus  = m;
        base     = b;
        start    = 1'b1;
        wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        t0       = cyc;
        run_id++;
        finished = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk); #1;
            start = (k == poke_at);
            base  = (k == poke_at) ? ~b : b;
            if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_mid_ctrl", W'({busy, done, wr_valid, wr_addr}), '0);
                chk("rst_mid_data", wr_data, '0);
                finished = 1'b1;
                break;
            end
            if (done_at >= 0 && k > done_at + 1) begin
                finished = 1'b1;
                break;
            end
        end
        start    = 1'b0;
        base     = b;
        wr_ready = 1'b1;
    endtask

    task automatic check_table(input logic [W-1:0] m, input logic [W-1:0] b, input int n, input bit timed);
        chk("nwrites", W'(log_addr.size()), W'(n));
        for (int i = 0; i < log_addr.size() && i < n; i++) begin
            chk($sformatf("addr[%0d]", i), W'(log_addr[i]), W'(i));
            chk($sformatf("data[%0d]", i), log_data[i], ref_entry(m, b, i));
            if (timed) chk($sformatf("wcyc[%0d]", i), W'(log_cyc[i]), W'(1 + 3 * i));
        end
        chk("stall_stable", W'(stall_err), '0);
        chk("done_count", W'(done_cnt), W'(1));
        if (timed) chk("done_cycle", W'(done_at), W'(95));
        chk("busy_c0", W'(busy0), W'(0));
        chk("busy_done", W'(busy_done), W'(1));
        chk("busy_after", W'(busy_after), W'(0));
        if (n > 0) chk("busy_c1", W'(busy1), W'(1));
    endtask

    initial begin
        logic [W-1:0] m_big, b_big;
        bit fin;

        reset = 1'b1; start = 1'b0; wr_ready = 1'b1; modulus = '0; base = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", W'({busy, done, wr_valid, wr_addr}), '0);
        chk("rst_data", wr_data, '0);
`ifdef XPB_GEN_CHECK_EN
        chk("rst_err", W'(err), '0);
`endif
        reset = 1'b0;

        // Small field, full throughput.
        run_table(W'(13), W'(5), 1'b0, -1, -1, fin);
        chk("small_finished", W'(fin), W'(1));
        check_table(W'(13), W'(5), N, 1'b1);
        chk("small_entry3", (log_data.size() > 3) ? log_data[3] : 'x, W'(2));

        // Full width, random odd modulus.
        for (int i = 0; i < W / 32; i++) begin
            m_big[i*32 +: 32] = $urandom();
            b_big[i*32 +: 32] = $urandom();
        end
        m_big[W-1] = 1'b1;
        m_big[0]   = 1'b1;
        b_big      = b_big % m_big;
        run_table(m_big, b_big, 1'b0, -1, -1, fin);
        chk("wide_finished", W'(fin), W'(1));
        chk("wide_entry1_is_B", (log_data.size() > 1) ? log_data[1] : 'x, b_big);
        check_table(m_big, b_big, N, 1'b1);

        // Random backpressure.
        run_table(W'(13), W'(5), 1'b1, -1, -1, fin);
        chk("bp_finished", W'(fin), W'(1));
        check_table(W'(13), W'(5), N, 1'b0);

        // Start pulse while busy must be ignored.
        run_table(W'(13), W'(5), 1'b0, 40, -1, fin);
        chk("poke_finished", W'(fin), W'(1));
        check_table(W'(13), W'(5), N, 1'b1);

        // Reset mid-run at cycle 50: entries 0..16 already written, nothing after.
        run_table(W'(13), W'(5), 1'b0, -1, 50, fin);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_run_nwrites", W'(log_addr.size()), W'(17));
        chk("rst_run_idle", W'({busy, wr_valid}), '0);
        for (int i = 0; i < log_data.size() && i < 17; i++)
            chk($sformatf("rst_run_data[%0d]", i), log_data[i], ref_entry(W'(13), W'(5), i));
        run_table(W'(13), W'(5), 1'b0, -1, -1, fin);
        chk("rerun_finished", W'(fin), W'(1));
        check_table(W'(13), W'(5), N, 1'b1);

`ifdef XPB_GEN_CHECK_EN
        run_table(W'(13), W'(13), 1'b0, -1, -1, fin);
        chk("rc_finished", W'(fin), W'(1));
        chk("rc_err_set", W'(err), W'(1));
        chk("rc_nwrites", W'(log_addr.size()), '0);
        chk("rc_done_count", W'(done_cnt), W'(1));
        run_table(W'(13), W'(5), 1'b0, -1, -1, fin);
        chk("rc2_finished", W'(fin), W'(1));
        chk("rc_err_clear", W'(err), '0);
        check_table(W'(13), W'(5), N, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
